mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 23 ++
 rtl/mul_div_signfix.sv | 13 +
 rtl/mul_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared op encodings, FSM state type and op decode helper for the
// iterative multiply/divide unit.
package mul_div_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b100;
    localparam logic [2:0] OP_SDIV  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) ||
               (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/mul_div_signfix.sv
// Conditional two's-complement negation; used both to take operand
// magnitudes and to restore the sign of results.
module mul_div_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with a sign-fix cycle at the end.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic               sign_diff_q, a_neg_q, ovf_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;
    logic [3:0]         flags_q;
    logic               err_q;

    logic op_legal, op_div, op_signed, div_zero, direct, accept;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_legal  = op_is_legal(op);
        op_div    = (op == OP_UDIV) || (op == OP_SDIV);
        op_signed = (op == OP_SMULL) || (op == OP_SDIV);
        div_zero  = op_div && (b == '0);
        direct    = !op_legal || div_zero;
        accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    mul_div_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .val_i(a), .neg_i(op_signed && a[WIDTH-1]), .res_o(mag_a)
    );
    mul_div_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .val_i(b), .neg_i(op_signed && b[WIDTH-1]), .res_o(mag_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = direct ? S_DONE : S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN:   if (cnt_q == LAST_CNT) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration step; acc holds {partial/remainder, multiplier/quotient}.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_take;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_take  = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (op_q[2]) begin
            acc_d = div_take ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_MUL;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_diff_q <= 1'b0;
            a_neg_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (accept) begin
            op_q        <= op;
            opnd_q      <= op_div ? mag_b : mag_a;
            acc_q       <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            cnt_q       <= '0;
            sign_diff_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            a_neg_q     <= op_signed && a[WIDTH-1];
            ovf_q       <= (op == OP_SDIV) && (a == MOST_NEG) && (b == '1);
        end else if (state_q == S_RUN) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_lo, fix_hi;
    logic [2*WIDTH-1:0] prod_fix;
    logic [3:0]         fix_flags;
    logic               wide;

    mul_div_signfix #(.WIDTH(WIDTH)) u_fix_quot (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(sign_diff_q), .res_o(quot_fix)
    );
    mul_div_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(a_neg_q), .res_o(rem_fix)
    );
    mul_div_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i(acc_q), .neg_i(sign_diff_q), .res_o(prod_fix)
    );

    always_comb begin
        fix_lo = '0;
        fix_hi = '0;
        wide   = 1'b0;
        case (op_q)
            OP_MUL:   fix_lo = acc_q[WIDTH-1:0];
            OP_UMULL: begin {fix_hi, fix_lo} = acc_q;    wide = 1'b1; end
            OP_SMULL: begin {fix_hi, fix_lo} = prod_fix; wide = 1'b1; end
            OP_UDIV:  begin fix_lo = acc_q[WIDTH-1:0]; fix_hi = acc_q[2*WIDTH-1:WIDTH]; end
            OP_SDIV:  begin fix_lo = quot_fix; fix_hi = rem_fix; end
            default: ;
        endcase
        fix_flags = {wide ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1],
                     wide ? ({fix_hi, fix_lo} == '0) : (fix_lo == '0),
                     1'b0, ovf_q};
    end

    // Error results are published on the accept edge; lo is zero, so only Z is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept && direct) begin
            res_lo_q <= '0;
            res_hi_q <= div_zero ? a : '0;
            flags_q  <= 4'b0100;
            err_q    <= 1'b1;
        end else if (state_q == S_FIX) begin
            res_lo_q <= fix_lo;
            res_hi_q <= fix_hi;
            flags_q  <= fix_flags;
            err_q    <= 1'b0;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an arithmetic reference model and a
// per-cycle compare process, plus hand-computed literal expectations.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, err;
    logic [W-1:0] result_lo, result_hi;
    logic [3:0]   flags;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi,
                                     output logic [3:0] fl, output logic er);
        logic [2*W-1:0] p;
        longint sx, sy;
        logic v, wide;
        lo = '0; hi = '0; er = 1'b0; v = 1'b0; wide = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'b000: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; lo = p[W-1:0]; end
            3'b001: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; {hi, lo} = p; wide = 1'b1; end
            3'b010: begin p = sx * sy; {hi, lo} = p; wide = 1'b1; end
            3'b100: begin
                if (y == 0) begin hi = x; er = 1'b1; end
                else begin lo = x / y; hi = x % y; end
            end
            3'b101: begin
                if (y == 0) begin hi = x; er = 1'b1; end
                else begin
                    p = sx / sy; lo = p[W-1:0];
                    p = sx % sy; hi = p[W-1:0];
                    v = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
                end
            end
            default: er = 1'b1;
        endcase
        fl = {wide ? hi[W-1] : lo[W-1], wide ? ({hi, lo} == 0) : (lo == 0), 1'b0, v};
    endfunction

    // Schedule model: edge index of accepts, busy window and done edge.
    int e_cnt = 0;
    int m_busy_first = -1000, m_busy_last = -1000, m_done_edge = -1000;
    logic [W-1:0] pend_lo = '0, pend_hi = '0;
    logic [3:0]   pend_fl = '0;
    logic         pend_err = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy_first = -1000;
            m_busy_last  = -1000;
            m_done_edge  = -1000;
        end else begin
            e_cnt++;
            if (start && (e_cnt - 1 > m_busy_last)) begin
                model_op(op, a, b, pend_lo, pend_hi, pend_fl, pend_err);
                if (pend_err) begin
                    m_busy_first = -1000;
                    m_busy_last  = -1000;
                    m_done_edge  = e_cnt;
                end else begin
                    m_busy_first = e_cnt;
                    m_busy_last  = e_cnt + W;
                    m_done_edge  = e_cnt + W + 1;
                end
            end
        end
    end

    logic [W-1:0] cur_lo = '0, cur_hi = '0;
    logic [3:0]   cur_fl = '0;
    logic         cur_err = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            cur_lo = '0; cur_hi = '0; cur_fl = '0; cur_err = 1'b0;
            check("cmp busy", busy, 0);
            check("cmp done", done, 0);
        end else begin
            if (e_cnt == m_done_edge) begin
                cur_lo = pend_lo; cur_hi = pend_hi; cur_fl = pend_fl; cur_err = pend_err;
            end
            check("cmp busy", busy, (e_cnt >= m_busy_first) && (e_cnt <= m_busy_last));
            check("cmp done", done, e_cnt == m_done_edge);
        end
        check("cmp result_lo", result_lo, cur_lo);
        check("cmp result_hi", result_hi, cur_hi);
        check("cmp flags", flags, cur_fl);
        check("cmp err", err, cur_err);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("done seen", done, 1);
    endtask

    // Operands are scrambled right after the accept edge; they must not matter.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        wait_done(lat);
    endtask

    task automatic expect_res(input string tag, input int lat, input int exp_lat,
                              input logic [W-1:0] lo, input logic [W-1:0] hi,
                              input logic [3:0] fl, input logic er);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " lo"}, result_lo, lo);
        check({tag, " hi"}, result_hi, hi);
        check({tag, " flags"}, flags, fl);
        check({tag, " err"}, err, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        idle(3);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset lo", result_lo, 0);
        check("reset flags", flags, 0);
        reset = 1'b1;

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        expect_res("umull max", lat, 34, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000, 1'b0);
        idle(2);
        issue(3'b010, 32'hFFFF_FFFD, 32'd7, lat);
        expect_res("smull -3*7", lat, 34, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        issue(3'b101, 32'hFFFF_FFF9, 32'd2, lat);
        expect_res("sdiv -7/2", lat, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        expect_res("sdiv min/-1", lat, 34, 32'h8000_0000, 32'h0, 4'b1001, 1'b0);
        issue(3'b101, 32'd7, 32'hFFFF_FFFE, lat);
        expect_res("sdiv 7/-2", lat, 34, 32'hFFFF_FFFD, 32'h1, 4'b1000, 1'b0);
        issue(3'b100, 32'd100, 32'd0, lat);
        expect_res("udiv 100/0", lat, 1, 32'h0, 32'd100, 4'b0100, 1'b1);
        issue(3'b111, 32'd5, 32'd5, lat);
        expect_res("illegal op", lat, 1, 32'h0, 32'h0, 4'b0100, 1'b1);
        issue(3'b001, 32'h8000_0000, 32'd2, lat);
        expect_res("umull 2^31*2", lat, 34, 32'h0, 32'h1, 4'b0000, 1'b0);
        issue(3'b000, 32'h0001_0000, 32'h0001_0000, lat);
        expect_res("mul wrap", lat, 34, 32'h0, 32'h0, 4'b0100, 1'b0);
        idle(1);

        // Back-to-back: start stays high through RUN (ignored) and into DONE.
        start = 1'b1; op = 3'b100; a = 32'd13; b = 32'd5;
        @(posedge clk); #1;
        op = 3'b000; a = 32'd6; b = 32'd7;
        wait_done(lat);
        expect_res("b2b udiv 13/5", lat, 34, 32'd2, 32'd3, 4'b0000, 1'b0);
        @(posedge clk); #1;
        check("b2b busy no gap", busy, 1);
        check("b2b done low", done, 0);
        start = 1'b0; a = $urandom; b = $urandom;
        wait_done(lat);
        expect_res("b2b mul 6*7", lat, 34, 32'd42, 32'd0, 4'b0000, 1'b0);

        // Reset in RUN cycle 10 abandons the operation.
        idle(1);
        start = 1'b1; op = 3'b001; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        idle(9);
        check("pre-reset busy", busy, 1);
        reset = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst lo", result_lo, 0);
        check("async rst hi", result_hi, 0);
        check("async rst flags", flags, 0);
        check("async rst err", err, 0);
        idle(2);
        reset = 1'b1;
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (done) nd++; end
        check("no done after reset", nd, 0);
        issue(3'b100, 32'd9, 32'd4, lat);
        expect_res("udiv 9/4", lat, 34, 32'd2, 32'd1, 4'b0000, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
